seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_PER_DIGIT, default 50000: i_clk cycles per digit slot (1 kHz slot rate at 50 MHz); legal range >= 4.
REQ-002 Parameter BLANK_CYC, default 500: blanking cycles at the start of each slot; legal range 1 <= BLANK_CYC < CLK_PER_DIGIT.
REQ-003 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_load_valid  input  1  new 8-digit frame offered.
REQ-006 o_load_ready  output  1  shadow buffer empty; frame accepted when i_load_valid & o_load_ready.
REQ-007 i_digits  input  40  8 digit codes, digit d at [5d+4:5d] = {dot, BCD nibble}; digit 0 is leftmost/most significant.
REQ-008 i_lz_en  input  1  leading-zero suppression enable, sampled each cycle.
REQ-009 o_cs  output  8  digit chip-selects, one-hot active-low; bit p selects digit p.
REQ-010 o_dig_ctrl  output  5  {dot, BCD} code of the selected digit, for the segment decoder.
REQ-011 o_blank  output  1  high = decoder must drive all segments off.
REQ-012 o_frame_start  output  1  one-cycle pulse at the start of digit 0's slot.

Function
REQ-013 Internal state: slot counter cnt (0..CLK_PER_DIGIT-1), 3-bit pointer ptr, active buffer (40 b), shadow buffer (40 b), pending flag.
REQ-014 cnt increments each cycle; at CLK_PER_DIGIT-1 it wraps to 0 and ptr increments, 7 wrapping to 0.
REQ-015 Two-state FSM per slot: BLANK while cnt < BLANK_CYC, SHOW otherwise; BLANK->SHOW at cnt == BLANK_CYC; SHOW->BLANK on slot wrap.
REQ-016 All outputs are registered: outputs in cycle n+1 reflect cnt/ptr/FSM state in cycle n.
REQ-017 BLANK: o_cs = 8'hFF, o_blank = 1, o_dig_ctrl = 5'h00.
REQ-018 SHOW: o_cs = ~(8'h01 << ptr), o_dig_ctrl = active code of digit ptr, o_blank = suppression result of REQ-019.
REQ-019 Suppression: with i_lz_en = 1, digit d (d = 0..6) is suppressed when every digit 0..d has code 5'h00; digit 7 is never suppressed; a suppressed digit shows o_cs per REQ-018 with o_blank = 1 and o_dig_ctrl = 5'h00; i_lz_en = 0 suppresses nothing.
REQ-020 Handshake: o_load_ready = ~pending; on acceptance, shadow <= i_digits and pending <= 1 at the same edge; o_load_ready falls in the next cycle.
REQ-021 Frame boundary = cycle with ptr == 7 and cnt == CLK_PER_DIGIT-1; if pending, active <= shadow and pending <= 0 at that edge; the new frame is visible from digit 0 onward.
REQ-022 Load accepted in the boundary cycle while pending = 0: stored in shadow, transferred at the next boundary (no bypass to active).
REQ-023 i_load_valid while o_load_ready = 0: ignored; shadow unchanged; the source holds data until accepted.
REQ-024 o_frame_start = 1 for exactly one cycle, the cycle after the boundary (first cycle of digit 0 BLANK, per REQ-016).
REQ-025 Active buffer never changes mid-frame; every frame displays one consistent 8-digit set.

Reset
REQ-026 While i_rst = 1 at a clock edge: cnt = 0, ptr = 0, FSM = BLANK, active = shadow = 40'h0, pending = 0.
REQ-027 Output reset values: o_cs = 8'hFF, o_dig_ctrl = 5'h00, o_blank = 1, o_load_ready = 1, o_frame_start = 0.
REQ-028 Reset asserted mid-slot or mid-handshake: abandons the slot; discards any pending shadow frame; takes precedence over load acceptance in the same cycle.
REQ-029 Scan restarts at digit 0 BLANK on the first edge with i_rst = 0; o_frame_start does not pulse for this restart.

Verification (CLK_PER_DIGIT = 10, BLANK_CYC = 2, frame = 80 cycles)
REQ-030 Reset, then free-run 160 cycles -> each slot shows 2 cycles o_cs = FF, then 8 cycles single low bit p; p runs 0..7 then wraps; o_frame_start pulses every 80 cycles.
REQ-031 Load {d0..d7} = 1,2,3,4,5,6,7,8 with dot on d1 at cycle 5 -> o_load_ready low from cycle 6; next frame shows o_dig_ctrl = 01,12,03,..,08; o_load_ready high after the boundary.
REQ-032 Second load attempted while pending -> no acceptance; displayed frame unchanged; accepted once o_load_ready returns.
REQ-033 Load in the exact boundary cycle with pending = 0 -> current frame is not updated; data is displayed from the following frame.
REQ-034 Frame 0,0,0,5,0,0,0,0 with i_lz_en = 1 -> digits 0-2 o_blank = 1, digits 3-7 o_blank = 0; all-zero frame -> only digit 7 unblanked; i_lz_en = 0 -> none blanked.
REQ-035 i_rst pulsed during ptr = 4 SHOW with pending = 1 -> outputs return to REQ-027 values; display restarts at digit 0 showing zeros; o_load_ready = 1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//
// Purpose:
//   Time-multiplexed scan controller for an 8-digit 7-segment display.
//   Each digit owns a slot of CLK_PER_DIGIT cycles. The first BLANK_CYC
//   cycles of a slot are blanked to suppress ghosting, and the rest show the
//   digit. New frames are written through a valid/ready handshake into a
//   shadow buffer. The shadow buffer is copied into the active buffer only at
//   the frame boundary, so every scan pass shows one consistent 8-digit set.
//   Optional leading-zero suppression blanks the zero digits that lead the
//   number, counting from digit 0 (leftmost). Digit 7 is never blanked.
//
// Parameters:
//   CLK_PER_DIGIT  cycles per digit slot (>= 4)
//   BLANK_CYC      blanking cycles at slot start (1 .. CLK_PER_DIGIT-1)
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_load_valid   new frame offered on i_digits
//   o_load_ready   shadow buffer empty; frame taken when valid & ready
//   i_digits[39:0] digit d at [5d+4:5d] = {dot, BCD}
//   i_lz_en        leading-zero suppression enable
//   o_cs[7:0]      one-hot active-low digit selects
//   o_dig_ctrl[4:0]{dot, BCD} of the selected digit
//   o_blank        decoder must drive all segments off
//   o_frame_start  one-cycle pulse as digit 0's slot begins
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int CLK_PER_DIGIT = 50000,
  parameter int BLANK_CYC     = 500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load_valid,
  output logic        o_load_ready,
  input  logic [39:0] i_digits,
  input  logic        i_lz_en,
  output logic [7:0]  o_cs,
  output logic [4:0]  o_dig_ctrl,
  output logic        o_blank,
  output logic        o_frame_start
);

  localparam int                CNT_W        = $clog2(CLK_PER_DIGIT);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(CLK_PER_DIGIT - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE_SHOW = CNT_W'(BLANK_CYC - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Code of one digit out of a packed 8-digit frame.
  function automatic logic [4:0] digit_code(input logic [39:0] frame,
                                            input logic [2:0]  idx);
    return frame[5*idx +: 5];
  endfunction

  // Suppression mask: bit d is set when digits 0..d are all code 0.
  // Digit 7 stays visible so an all-zero frame still reads "0".
  function automatic logic [7:0] lz_mask(input logic [39:0] frame,
                                         input logic        en);
    logic [7:0] mask;
    logic       all_zero;
    mask     = 8'h00;
    all_zero = 1'b1;
    for (int d = 0; d < 7; d++) begin
      all_zero = all_zero && (frame[5*d +: 5] == 5'h00);
      mask[d]  = en && all_zero;
    end
    return mask;
  endfunction

  // ---- stage p0: slot timing, FSM and frame buffers ----
  logic [CNT_W-1:0] cnt_p0;
  logic [2:0]       ptr_p0;
  state_t           state_p0;
  state_t           state_nxt;
  logic [39:0]      active_p0;
  logic [39:0]      shadow_p0;
  logic             pending_p0;
  logic             slot_end;
  logic             frame_end;

  assign slot_end  = (cnt_p0 == CNT_LAST);
  assign frame_end = slot_end && (ptr_p0 == 3'd7);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_p0 <= '0;
      ptr_p0 <= 3'd0;
    end else if (slot_end) begin
      cnt_p0 <= '0;
      ptr_p0 <= ptr_p0 + 3'd1;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_p0 <= ST_BLANK;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  // State tracks the counter: SHOW is entered in the cycle where
  // cnt == BLANK_CYC, so the transition is taken one count earlier.
  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      ST_BLANK: if (!slot_end && (cnt_p0 == CNT_PRE_SHOW)) state_nxt = ST_SHOW;
      ST_SHOW:  if (slot_end)                              state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  // Transfer and acceptance are exclusive because acceptance needs an
  // empty shadow. A load in the boundary cycle with an empty shadow
  // therefore waits a whole frame and is never passed straight to active.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active_p0  <= '0;
      shadow_p0  <= '0;
      pending_p0 <= 1'b0;
    end else if (frame_end && pending_p0) begin
      active_p0  <= shadow_p0;
      pending_p0 <= 1'b0;
    end else if (i_load_valid && !pending_p0) begin
      shadow_p0  <= i_digits;
      pending_p0 <= 1'b1;
    end
  end

  assign o_load_ready = ~pending_p0;

  // ---- stage p1: registered display outputs ----
  logic [7:0] cs_nxt;
  logic [4:0] dig_nxt;
  logic       blank_nxt;
  logic [7:0] sup_mask;

  logic [7:0] cs_p1;
  logic [4:0] dig_p1;
  logic       blank_p1;
  logic       fstart_p1;

  assign sup_mask = lz_mask(active_p0, i_lz_en);

  always_comb begin
    cs_nxt    = 8'hFF;
    dig_nxt   = 5'h00;
    blank_nxt = 1'b1;
    if (state_p0 == ST_SHOW) begin
      cs_nxt = ~(8'h01 << ptr_p0);
      if (sup_mask[ptr_p0]) begin
        blank_nxt = 1'b1;
        dig_nxt   = 5'h00;
      end else begin
        blank_nxt = 1'b0;
        dig_nxt   = digit_code(active_p0, ptr_p0);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cs_p1     <= 8'hFF;
      dig_p1    <= 5'h00;
      blank_p1  <= 1'b1;
      fstart_p1 <= 1'b0;
    end else begin
      cs_p1     <= cs_nxt;
      dig_p1    <= dig_nxt;
      blank_p1  <= blank_nxt;
      fstart_p1 <= frame_end;
    end
  end

  assign o_cs          = cs_p1;
  assign o_dig_ctrl    = dig_p1;
  assign o_blank       = blank_p1;
  assign o_frame_start = fstart_p1;

endmodule
